// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the multi-cycle multiply/divide sequencer.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int         MDU_ITERS     = 32;
  localparam logic [4:0] MDU_LAST_ITER = 5'(MDU_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (64'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iteration datapath: unsigned shift-add multiply or restoring divide, one step per strobe.
module mdu_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] step_hi,
  output logic [31:0] step_lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] b_q, b_d;
  logic        div_q, div_d;
  logic [32:0] shifted;
  logic [32:0] sum;
  logic        fits;

  // One iteration of the selected algorithm plus start/step register update.
  always_comb begin
    shifted = {hi_q, lo_q[31]};
    fits    = shifted >= {1'b0, b_q};
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    if (div_q) begin
      if (fits) begin
        step_hi = shifted[31:0] - b_q;
        step_lo = {lo_q[30:0], 1'b1};
      end else begin
        step_hi = shifted[31:0];
        step_lo = {lo_q[30:0], 1'b0};
      end
    end else begin
      step_hi = sum[32:1];
      step_lo = {sum[0], lo_q[31:1]};
    end

    if (start) begin
      hi_d  = 32'd0;
      lo_d  = a_in;
      b_d   = b_in;
      div_d = is_div;
    end else if (step) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      b_d   = b_q;
      div_d = div_q;
    end else begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      b_d   = b_q;
      div_d = div_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      b_q   <= 32'd0;
      div_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// EX-stage multiply/divide sequencer: accepts an op, stalls the pipe for 33 cycles,
// then presents a registered HI/LO result until the pipeline releases it.
module mdu_seq
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        bz_q, bz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        core_start, core_step;
  logic        in_signed;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod;

  assign in_signed = ~op[0];

  mdu_core u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .step    (core_step),
    .is_div  (op[1]),
    .a_in    (cond_neg32(src_a, in_signed & src_a[31])),
    .b_in    (cond_neg32(src_b, in_signed & src_b[31])),
    .step_hi (step_hi),
    .step_lo (step_lo)
  );

  // Next-state, counter, sign capture and sign fix-up of the final iteration.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    bz_d       = bz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    core_start = 1'b0;
    core_step  = 1'b0;
    prod       = cond_neg64({step_hi, step_lo}, sa_q ^ sb_q);

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          state_d    = ST_RUN;
          cnt_d      = 5'd0;
          op_d       = op;
          sa_d       = in_signed & src_a[31];
          sb_d       = in_signed & src_b[31];
          bz_d       = (src_b == 32'd0);
          core_start = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        core_step = 1'b1;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == MDU_LAST_ITER) begin
          state_d = ST_DONE;
          // With a zero divisor the restoring loop leaves |a| in the remainder and
          // all ones in the quotient, so re-applying the dividend sign restores src_a.
          if (op_q[1]) begin
            hi_d = cond_neg32(step_hi, sa_q);
            lo_d = bz_q ? step_lo : cond_neg32(step_lo, sa_q ^ sb_q);
          end else begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!hold) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) begin
      state_d    = ST_IDLE;
      cnt_d      = 5'd0;
      core_start = 1'b0;
      core_step  = 1'b0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // Sequencer state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'b00;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stallreq     = op_valid & ~flush & ~rst & ((state_q == ST_IDLE) | (state_q == ST_RUN));
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign result_hi    = hi_q;
  assign result_lo    = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: arithmetic reference model plus per-cycle handshake expectations.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst, flush, hold, op_valid;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, busy, result_valid;
  logic [31:0] result_hi, result_lo;

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_busy, exp_valid, exp_res;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  mdu_seq dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .hold         (hold),
    .op_valid     (op_valid),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .stallreq     (stallreq),
    .busy         (busy),
    .result_valid (result_valid),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic, {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (o == 2'b00) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      return 64'(x * y);
    end
    if (o == 2'b01) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == 2'b10) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stallreq", 32'(stallreq), 32'(exp_stall));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("result_valid", 32'(result_valid), 32'(exp_valid));
      if (exp_res) begin
        chk("result_hi", result_hi, exp_hi);
        chk("result_lo", result_lo, exp_lo);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_st(input logic s, input logic b, input logic v, input logic r);
    exp_stall = s;
    exp_busy  = b;
    exp_valid = v;
    exp_res   = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      rst = 1'b0; flush = 1'b0; hold = 1'b0; op_valid = 1'b0;
      expect_st(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One instruction through EX; kill_at in 1..32 aborts in RUN by flush or rst.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold_n, input int kill_at, input logic kill_rst,
                        input logic flush_done);
    logic [63:0] m;
    m = model(o, a, b);
    cyc();
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    expect_st(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      cyc();
      hold = 1'($urandom_range(0, 1));
      if (c == kill_at) begin
        if (kill_rst) rst = 1'b1;
        else flush = 1'b1;
        expect_st(1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        rst = 1'b0; flush = 1'b0; hold = 1'b0; op_valid = 1'b0;
        expect_st(1'b0, 1'b0, 1'b0, kill_rst);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        return;
      end
      expect_st(1'b1, 1'b1, 1'b0, 1'b0);
    end
    for (int d = 0; d <= hold_n; d++) begin
      cyc();
      hold  = (d < hold_n);
      flush = flush_done && (d == hold_n);
      expect_st(1'b0, 1'b1, 1'b1, 1'b1);
      exp_hi = m[63:32];
      exp_lo = m[31:0];
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] m;
    rst = 1'b1; flush = 1'b0; hold = 1'b0; op_valid = 1'b1;
    op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    expect_st(1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_en = 1'b1;
    expect_st(1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    idle(2);

    m = model(2'b01, 32'hFFFF_FFFF, 32'd2);
    chk("pin_multu_hi", m[63:32], 32'h0000_0001);
    chk("pin_multu_lo", m[31:0], 32'hFFFF_FFFE);
    m = model(2'b00, 32'hFFFF_FFFD, 32'd5);
    chk("pin_mult_hi", m[63:32], 32'hFFFF_FFFF);
    chk("pin_mult_lo", m[31:0], 32'hFFFF_FFF1);
    m = model(2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("pin_div_hi", m[63:32], 32'hFFFF_FFFF);
    chk("pin_div_lo", m[31:0], 32'hFFFF_FFFD);
    m = model(2'b11, 32'd100, 32'd7);
    chk("pin_divu_hi", m[63:32], 32'd2);
    chk("pin_divu_lo", m[31:0], 32'd14);
    m = model(2'b10, 32'h1234_5678, 32'd0);
    chk("pin_div0_hi", m[63:32], 32'h1234_5678);
    chk("pin_div0_lo", m[31:0], 32'hFFFF_FFFF);

    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 0, 0, 1'b0, 1'b0);
    idle(1);
    run_op(2'b11, 32'h1234_5678, 32'd0, 0, 0, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 0, 0, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    run_op(2'b10, 32'd1000, 32'd3, 0, 10, 1'b0, 1'b0);
    run_op(2'b00, 32'd123456, 32'hFFFF_FF85, 0, 0, 1'b0, 1'b0);
    run_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 5, 0, 1'b0, 1'b0);
    run_op(2'b11, 32'hCAFE_F00D, 32'd17, 0, 0, 1'b0, 1'b1);
    idle(1);
    cyc();
    op_valid = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    expect_st(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    run_op(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 20, 1'b1, 1'b0);
    idle(1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 2, 32, 1'b0, 1'b0);
    idle(1);

    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom_range(0, 3)), rnd_val(), rnd_val(), int'($urandom_range(0, 3)), 0, 1'b0, 1'b0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
